// File: rtl/reg10_pkg.sv
// Shared types for the 10-bit register bank and its round-robin access arbiter.
package reg10_pkg;

    localparam int DATA_W = 10;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

endpackage

// File: rtl/reg10_bank.sv
// DEPTH x 10-bit register bank: one write port and one combinational read port.
module reg10_bank
    import reg10_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd
);

    data_t regs [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                regs[i] <= '0;
            end else if (we && (waddr == ADDR_W'(i))) begin
                regs[i] <= wdata;
            end
        end
    end

    assign rd = regs[raddr];

endmodule

// File: rtl/reg10_access_arbiter.sv
// Round-robin arbiter giving NREQ requesters single read/write accesses to a shared 10-bit bank.
// Define REG_ARB_LOCK_EN to add the lock port, which lets a winner keep the grant up to MAX_LOCK times.
module reg10_access_arbiter
    import reg10_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DEPTH    = 4,
`ifdef REG_ARB_LOCK_EN
    parameter int MAX_LOCK = 4,
`endif
    parameter int ADDR_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic [NREQ-1:0]          lock,
`endif
    output logic [NREQ-1:0]          gnt,
    output logic                     rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(NREQ)-1:0]  rid,
    output logic                     busy
);

    localparam int RID_W = $clog2(NREQ);

    arb_state_t        state, state_d;
    logic [RID_W-1:0]  rr_ptr;
    logic [RID_W-1:0]  pick;
    logic              pick_ok;
    logic              load;
    logic              acc;
    logic [RID_W-1:0]  next_ptr;

    logic [RID_W-1:0]  win_p0;
    logic              we_p0;
    logic [ADDR_W-1:0] addr_p0;
    data_t             wdata_p0;

    logic              bank_we;
    data_t             rd;

    // First requester at or after rr_ptr, wrapping NREQ-1 -> 0 by explicit compare.
    always_comb begin
        int idx_i;
        logic [RID_W-1:0] idx;
        pick    = '0;
        pick_ok = 1'b0;
        idx_i   = 0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_i = int'(rr_ptr) + k;
            if (idx_i >= NREQ) idx_i = idx_i - NREQ;
            idx = RID_W'(idx_i);
            if (!pick_ok && req[idx]) begin
                pick_ok = 1'b1;
                pick    = idx;
            end
        end
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        acc     = 1'b0;
        gnt     = '0;
        case (state)
            IDLE: begin
                if (pick_ok) begin
                    state_d = ACCESS;
                    load    = 1'b1;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                acc     = 1'b1;
                // A reset landing on the ACCESS cycle aborts it, so the grant is suppressed too.
                for (int i = 0; i < NREQ; i++) begin
                    gnt[i] = !reset && (win_p0 == RID_W'(i));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign next_ptr = (win_p0 == RID_W'(NREQ - 1)) ? '0 : win_p0 + RID_W'(1);
    assign bank_we  = acc && we_p0 && !reset;
    assign busy     = (state == ACCESS);

    // Stage p0: operands latched at the IDLE decision; later changes on the inputs are ignored.
    always_ff @(posedge clk) begin
        if (load) begin
            win_p0   <= pick;
            we_p0    <= we[pick];
            addr_p0  <= addr[pick*ADDR_W +: ADDR_W];
            wdata_p0 <= wdata[pick*DATA_W +: DATA_W];
        end
    end

`ifdef REG_ARB_LOCK_EN
    localparam int LCNT_W = $clog2(MAX_LOCK) + 1;

    logic [LCNT_W-1:0] lock_cnt;
    logic [LCNT_W-1:0] cnt_eff;
    logic [RID_W-1:0]  last_win;
    logic              hold;

    // The count only carries over while the same requester keeps winning.
    assign cnt_eff = (win_p0 == last_win) ? lock_cnt : '0;
    assign hold    = lock[win_p0] && (int'(cnt_eff) < MAX_LOCK - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt <= '0;
            last_win <= '0;
        end else if (acc) begin
            last_win <= win_p0;
            lock_cnt <= hold ? cnt_eff + LCNT_W'(1) : '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
            rid    <= '0;
        end else begin
            state  <= state_d;
            rvalid <= acc && !we_p0;
            if (acc && !we_p0) begin
                rdata <= rd;
                rid   <= win_p0;
            end
            if (acc) begin
`ifdef REG_ARB_LOCK_EN
                rr_ptr <= hold ? win_p0 : next_ptr;
`else
                rr_ptr <= next_ptr;
`endif
            end
        end
    end

    reg10_bank #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .we    (bank_we),
        .waddr (addr_p0),
        .wdata (wdata_p0),
        .raddr (addr_p0),
        .rd    (rd)
    );

endmodule

// File: tb/tb_reg10_access_arbiter.sv
// Directed self-checking bench for reg10_access_arbiter (lock scenario only with REG_ARB_LOCK_EN).
module tb_reg10_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [3:0]  lock;
    logic [7:0]  addr;
    logic [39:0] wdata;
    logic [3:0]  gnt;
    logic        rvalid;
    logic [9:0]  rdata;
    logic [1:0]  rid;
    logic        busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    reg10_access_arbiter #(
        .NREQ   (4),
        .DEPTH  (4),
        .ADDR_W (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
`ifdef REG_ARB_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .rid    (rid),
        .busy   (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        g = 4'h0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gnt !== 4'h0) begin
                g = gnt;
                break;
            end
        end
    endtask

    task automatic run_one(input int r, input logic w, input logic [1:0] a, input logic [9:0] d,
                           output logic [3:0] g, output logic rv, output logic [9:0] rd,
                           output logic [1:0] id);
        req = 4'h0;
        we  = 4'h0;
        req[r] = 1'b1;
        we[r]  = w;
        addr[r*2 +: 2]   = a;
        wdata[r*10 +: 10] = d;
        wait_gnt(g);
        req = 4'h0;
        step();
        rv = rvalid;
        rd = rdata;
        id = rid;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'h0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] g;
        logic rv;
        logic [9:0] rd;
        logic [1:0] id;
        reset = 1'b1;
        req   = 4'hF;
        we    = 4'h0;
        for (int c = 0; c < 2; c++) begin
            step();
            total++; if (gnt !== 4'h0) $display("FAIL reset_gnt: got %h want 0", gnt); else passed++;
            total++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid); else passed++;
            total++; if (rdata !== 10'h000) $display("FAIL reset_rdata: got %h want 000", rdata); else passed++;
            total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        end
        total++; if (rid !== 2'd0) $display("FAIL reset_rid: got %0d want 0", rid); else passed++;
        reset = 1'b0;
        req   = 4'h0;
        step();
        for (int a = 0; a < 4; a++) begin
            run_one(0, 1'b0, 2'(a), 10'h000, g, rv, rd, id);
            total++; if (rv !== 1'b1) $display("FAIL reset_bank_rvalid[%0d]: got %b want 1", a, rv); else passed++;
            total++; if (rd !== 10'h000) $display("FAIL reset_bank[%0d]: got %h want 000", a, rd); else passed++;
        end
    endtask

    task automatic test_single_rw();
        logic [3:0] g;
        logic rv;
        logic [9:0] rd;
        logic [1:0] id;
        run_one(0, 1'b1, 2'd2, 10'h2A5, g, rv, rd, id);
        total++; if (g !== 4'h1) $display("FAIL wr_gnt: got %h want 1", g); else passed++;
        total++; if (rv !== 1'b0) $display("FAIL wr_rvalid: got %b want 0", rv); else passed++;
        run_one(0, 1'b0, 2'd2, 10'h000, g, rv, rd, id);
        total++; if (g !== 4'h1) $display("FAIL rd_gnt: got %h want 1", g); else passed++;
        total++; if (rv !== 1'b1) $display("FAIL rd_rvalid: got %b want 1", rv); else passed++;
        total++; if (rd !== 10'h2A5) $display("FAIL rd_data: got %h want 2a5", rd); else passed++;
        total++; if (id !== 2'd0) $display("FAIL rd_rid: got %0d want 0", id); else passed++;
        step();
        total++; if (rvalid !== 1'b0) $display("FAIL rvalid_pulse: got %b want 0", rvalid); else passed++;
        total++; if (rdata !== 10'h2A5) $display("FAIL rdata_hold: got %h want 2a5", rdata); else passed++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        logic [3:0] g;
        logic rv;
        logic [9:0] rd;
        logic [1:0] id;
        exp_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        do_reset();
        req   = 4'hF;
        we    = 4'hF;
        addr  = 8'b11_10_01_00;
        wdata = {10'h103, 10'h102, 10'h101, 10'h100};
        for (int i = 0; i < 5; i++) begin
            wait_gnt(g);
            total++; if (g !== exp_seq[i]) $display("FAIL rr_gnt[%0d]: got %h want %h", i, g, exp_seq[i]); else passed++;
        end
        req = 4'h0;
        step();
        for (int i = 0; i < 4; i++) begin
            run_one(3, 1'b0, 2'(i), 10'h000, g, rv, rd, id);
            total++; if (rd !== 10'(10'h100 + i)) $display("FAIL rr_bank[%0d]: got %h want %h", i, rd, 10'(10'h100 + i)); else passed++;
            total++; if (id !== 2'd3) $display("FAIL rr_rid[%0d]: got %0d want 3", i, id); else passed++;
        end
    endtask

    task automatic test_reset_mid_access();
        logic [3:0] g;
        req   = 4'h0;
        we    = 4'h0;
        req[2] = 1'b1;
        we[2]  = 1'b1;
        addr[5:4]   = 2'd1;
        wdata[29:20] = 10'h3FF;
        step();
        total++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy); else passed++;
        total++; if (gnt !== 4'h4) $display("FAIL abort_gnt_before: got %h want 4", gnt); else passed++;
        reset = 1'b1;
        req   = 4'h0;
        #1;
        total++; if (gnt !== 4'h0) $display("FAIL abort_gnt: got %h want 0", gnt); else passed++;
        step();
        reset = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy_after: got %b want 0", busy); else passed++;
        total++; if (rvalid !== 1'b0) $display("FAIL abort_rvalid: got %b want 0", rvalid); else passed++;
        req  = 4'hF;
        we   = 4'h0;
        addr = 8'b01_01_01_01;
        wait_gnt(g);
        total++; if (g !== 4'h1) $display("FAIL abort_ptr_gnt: got %h want 1", g); else passed++;
        req = 4'h0;
        step();
        total++; if (rvalid !== 1'b1) $display("FAIL abort_rd_rvalid: got %b want 1", rvalid); else passed++;
        total++; if (rdata !== 10'h000) $display("FAIL abort_bank1: got %h want 000", rdata); else passed++;
    endtask

    task automatic test_wrap_skip();
        logic [3:0] g;
        logic rv;
        logic [9:0] rd;
        logic [1:0] id;
        run_one(2, 1'b1, 2'd3, 10'h155, g, rv, rd, id);
        total++; if (g !== 4'h4) $display("FAIL wrap_setup_gnt: got %h want 4", g); else passed++;
        req  = 4'b0101;
        we   = 4'h0;
        addr = 8'b00_11_00_00;
        wait_gnt(g);
        total++; if (g !== 4'h1) $display("FAIL wrap_first_gnt: got %h want 1", g); else passed++;
        req[0] = 1'b0;
        step();
        total++; if (rvalid !== 1'b1) $display("FAIL wrap_first_rvalid: got %b want 1", rvalid); else passed++;
        total++; if (rid !== 2'd0) $display("FAIL wrap_first_rid: got %0d want 0", rid); else passed++;
        total++; if (rdata !== 10'h000) $display("FAIL wrap_first_rdata: got %h want 000", rdata); else passed++;
        wait_gnt(g);
        total++; if (g !== 4'h4) $display("FAIL wrap_second_gnt: got %h want 4", g); else passed++;
        req = 4'h0;
        step();
        total++; if (rid !== 2'd2) $display("FAIL wrap_second_rid: got %0d want 2", rid); else passed++;
        total++; if (rdata !== 10'h155) $display("FAIL wrap_second_rdata: got %h want 155", rdata); else passed++;
    endtask

`ifdef REG_ARB_LOCK_EN
    task automatic test_lock();
        logic [3:0] exp_seq [6];
        logic [3:0] g;
        exp_seq = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4};
        do_reset();
        req  = 4'hF;
        we   = 4'h0;
        addr = 8'h00;
        lock = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            wait_gnt(g);
            total++; if (g !== exp_seq[i]) $display("FAIL lock_gnt[%0d]: got %h want %h", i, g, exp_seq[i]); else passed++;
        end
        req  = 4'h0;
        lock = 4'h0;
        step();
    endtask
`endif

    initial begin
        reset = 1'b1;
        req   = 4'h0;
        we    = 4'h0;
        lock  = 4'h0;
        addr  = 8'h00;
        wdata = 40'h0;
        test_reset();
        test_single_rw();
        test_round_robin();
        test_reset_mid_access();
        test_wrap_skip();
`ifdef REG_ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
